// File: rtl/dram_line_reader.sv
// dram_line_reader: AXI4 read master for the HDMI line fetch.
// It accepts one line request, issues INCR bursts that never cross a 4 KB
// page and streams the returned words to the pixel FIFO as buf_dout/buf_we.
//
// Handshake: an AXI transfer happens on a rising clk edge where both valid and
// ready are high. While arvalid is high, araddr/arlen are held stable. rready
// is high for the whole R state and is never withdrawn there. buf_we is a
// one-cycle strobe with no backpressure.
module dram_line_reader #(
  parameter int MAX_BURST = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kick,
  output logic              busy,
  input  logic [31:0]       read_addr,
  input  logic [31:0]       read_num,
  output logic [31:0]       buf_dout,
  output logic              buf_we,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  localparam logic [10:0] MAX_B = 11'(MAX_BURST);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       rem_q, rem_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              buf_we_q, buf_we_d;
  logic [31:0]       buf_dout_q, buf_dout_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;

  // Candidate address/remaining count for the next burst and its length.
  logic [31:0] nxt_addr;
  logic [31:0] nxt_rem;
  logic [10:0] room;
  logic [10:0] lim;
  logic [8:0]  nxt_len;
  logic        load_burst;

  // Next burst origin: fresh request in IDLE, otherwise the end of the current burst.
  always_comb begin
    nxt_addr = addr_q + {21'd0, len_q, 2'b00};
    nxt_rem  = rem_q - {23'd0, len_q};
    if (state_q == S_IDLE) begin
      nxt_addr = {read_addr[31:2], 2'b00};
      nxt_rem  = read_num;
    end
  end

  // Burst length: limited by remaining words, MAX_BURST and words left in the 4 KB page.
  always_comb begin
    room    = 11'd1024 - {1'b0, nxt_addr[11:2]};
    lim     = (room < MAX_B) ? room : MAX_B;
    nxt_len = (nxt_rem < {21'd0, lim}) ? nxt_rem[8:0] : lim[8:0];
  end

  // Next-state and output logic of the request FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    hold_d     = hold_q;
    err_d      = err_q;
    buf_we_d   = 1'b0;
    buf_dout_d = buf_dout_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    load_burst = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (kick) begin
          addr_d = nxt_addr;
          rem_d  = nxt_rem;
          busy_d = 1'b1;
          if (nxt_rem == 32'd0) begin
            // Empty request still shows a two-cycle busy pulse.
            state_d = S_DONE;
            hold_d  = 1'b1;
          end else begin
            load_burst = 1'b1;
          end
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          buf_dout_d = m_axi_rdata;
          buf_we_d   = 1'b1;
          cnt_d      = cnt_q - 9'd1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (cnt_q == 9'd1) begin
            // Our own beat count ends the burst, whatever rlast says.
            if (!m_axi_rlast) err_d = 1'b1;
            addr_d = nxt_addr;
            rem_d  = nxt_rem;
            if (nxt_rem == 32'd0) state_d = S_DONE;
            else                  load_burst = 1'b1;
          end else if (m_axi_rlast) begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_burst) begin
      state_d   = S_AR;
      len_d     = nxt_len;
      cnt_d     = nxt_len;
      arvalid_d = 1'b1;
      araddr_d  = ADDR_W'(nxt_addr);
      arlen_d   = 8'(nxt_len - 9'd1);
    end
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_dout_q <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      buf_we_q   <= buf_we_d;
      buf_dout_q <= buf_dout_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
    end
  end

  assign busy          = busy_q;
  assign buf_dout      = buf_dout_q;
  assign buf_we        = buf_we_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_R);
  assign err           = err_q;

endmodule

// File: tb/tb_dram_line_reader.sv
// Testbench for dram_line_reader: table of line requests against a small
// AXI read slave, plus hand-written zero-length, kick-while-busy and reset cases.
module tb_dram_line_reader;

  logic        clk;
  logic        rst;
  logic        kick;
  logic        busy;
  logic [31:0] read_addr;
  logic [31:0] read_num;
  logic [31:0] buf_dout;
  logic        buf_we;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        err;

  dram_line_reader #(.MAX_BURST(256), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .kick(kick), .busy(busy),
    .read_addr(read_addr), .read_num(read_num),
    .buf_dout(buf_dout), .buf_we(buf_we),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .err(err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] num;
    int          stall;       // arready low cycles per AR
    bit          toggle;      // rvalid on alternate cycles
    int          resp_beat;   // global beat (1-based) answered with SLVERR, 0 = none
    int          early_last;  // beat within burst carrying a premature rlast, 0 = none
    bit          drop_last;   // omit rlast on the final beat
    int          exp_ars;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] al;
    logic [7:0]  ll;
    bit          exp_err;
  } vec_t;

  // Scoreboard and counters
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Slave / monitor state
  int          cyc;
  int          cfg_stall, cfg_resp_beat, cfg_early_last;
  bit          cfg_toggle, cfg_drop_last;
  bit          s_active;
  logic [31:0] s_addr;
  int          s_len, s_beat, g_beat, ar_wait;
  int          ar_cnt, words, last_we_cyc, fall_cyc;
  bit          seen_busy, any_arvalid;
  logic [31:0] ar0_addr, arl_addr, held_addr;
  logic [7:0]  ar0_len, arl_len, held_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic slave_clear();
    s_active = 0; s_beat = 0; s_len = 0; g_beat = 0; ar_wait = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 0;
  endtask

  task automatic stats_clear();
    ar_cnt = 0; words = 0; last_we_cyc = 0; fall_cyc = 0;
    seen_busy = 0; any_arvalid = 0;
    ar0_addr = '0; ar0_len = '0; arl_addr = '0; arl_len = '0;
    exp_q.delete();
  endtask

  // One cycle: observe outputs at negedge, then drive slave inputs for the next posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (buf_we) begin
      words++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_word: got %0h expected none", buf_dout);
      end else begin
        chk("data", buf_dout, exp_q.pop_front());
      end
    end
    if (busy) seen_busy = 1;
    else if (seen_busy && fall_cyc == 0) fall_cyc = cyc;
    if (m_axi_arvalid) any_arvalid = 1;
    // R channel
    if (s_active && (!cfg_toggle || (cyc % 2 == 0))) begin
      m_axi_rvalid = 1;
      m_axi_rdata  = 32'hD000_0000 + (s_addr >> 2) + 32'(s_beat);
      m_axi_rresp  = (g_beat + 1 == cfg_resp_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (s_beat + 1 == s_len) ? !cfg_drop_last : (s_beat + 1 == cfg_early_last);
      if (m_axi_rready) begin
        s_beat++; g_beat++;
        if (s_beat == s_len) s_active = 0;
      end
    end else begin
      m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
    end
    // AR channel
    if (m_axi_arvalid) begin
      if (ar_wait == 0) begin
        held_addr = m_axi_araddr; held_len = m_axi_arlen;
      end else begin
        chk("araddr_stable", m_axi_araddr, held_addr);
        chk("arlen_stable", {24'd0, m_axi_arlen}, {24'd0, held_len});
      end
      m_axi_arready = (ar_wait >= cfg_stall);
      if (m_axi_arready) begin
        if (ar_cnt == 0) begin ar0_addr = m_axi_araddr; ar0_len = m_axi_arlen; end
        arl_addr = m_axi_araddr; arl_len = m_axi_arlen;
        ar_cnt++;
        s_active = 1; s_addr = m_axi_araddr; s_len = int'(m_axi_arlen) + 1; s_beat = 0;
        ar_wait = 0;
      end else begin
        ar_wait++;
      end
    end else begin
      m_axi_arready = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1; kick = 0;
    slave_clear();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_buf_we"}, buf_we, 0);
    chk({tag, "_buf_dout"}, buf_dout, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_vector(input vec_t v, input bit with_reset, input bit mid_kick);
    int budget;
    bit rebusy;
    if (with_reset) do_reset();
    stats_clear();
    cfg_stall = v.stall; cfg_toggle = v.toggle; cfg_resp_beat = v.resp_beat;
    cfg_early_last = v.early_last; cfg_drop_last = v.drop_last;
    for (int i = 0; i < int'(v.num); i++)
      exp_q.push_back(32'hD000_0000 + {2'b00, v.addr[31:2]} + 32'(i));
    read_addr = v.addr; read_num = v.num; kick = 1;
    step();
    kick = 0;
    budget = 0;
    while (fall_cyc == 0 && budget < 6000) begin
      if (mid_kick && budget == 2) begin
        read_addr = 32'h0000_9000; read_num = 32'd100; kick = 1;
      end
      step();
      kick = 0;
      budget++;
    end
    if (fall_cyc == 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: busy still %0b after %0d cycles", busy, budget);
    end
    chk("ar_count", ar_cnt, v.exp_ars);
    chk("ar0_addr", ar0_addr, v.a0);
    chk("ar0_len", {24'd0, ar0_len}, {24'd0, v.l0});
    chk("arlast_addr", arl_addr, v.al);
    chk("arlast_len", {24'd0, arl_len}, {24'd0, v.ll});
    chk("word_count", words, v.num);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("err", err, v.exp_err);
    chk("busy_fall", fall_cyc, last_we_cyc + 1);
    if (mid_kick) begin
      rebusy = 0;
      repeat (6) begin step(); if (busy || m_axi_arvalid) rebusy = 1; end
      chk("no_restart", rebusy, 0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int budget;
    int busy_cnt;
    vec_t v;
    // addr, num, stall, toggle, resp, early, drop, ars, a0, l0, al, ll, err
    vecs[0] = '{32'h1000, 32'd16,   0, 0, 0, 0, 0, 1, 32'h1000, 8'd15,  32'h1000, 8'd15,  0};
    vecs[1] = '{32'h0000, 32'd1280, 0, 0, 0, 0, 0, 5, 32'h0000, 8'd255, 32'h1000, 8'd255, 0};
    vecs[2] = '{32'h0FF0, 32'd8,    0, 0, 0, 0, 0, 2, 32'h0FF0, 8'd3,   32'h1000, 8'd3,   0};
    vecs[3] = '{32'h2000, 32'd40,   5, 1, 0, 0, 0, 1, 32'h2000, 8'd39,  32'h2000, 8'd39,  0};
    vecs[4] = '{32'h1003, 32'd1,    0, 0, 0, 0, 0, 1, 32'h1000, 8'd0,   32'h1000, 8'd0,   0};
    vecs[5] = '{32'h3000, 32'd6,    0, 0, 3, 0, 0, 1, 32'h3000, 8'd5,   32'h3000, 8'd5,   1};
    vecs[6] = '{32'h4000, 32'd4,    0, 0, 0, 2, 0, 1, 32'h4000, 8'd3,   32'h4000, 8'd3,   1};
    vecs[7] = '{32'h5000, 32'd4,    0, 0, 0, 0, 1, 1, 32'h5000, 8'd3,   32'h5000, 8'd3,   1};
    vecs[8] = '{32'h0F00, 32'd300,  2, 0, 0, 0, 0, 2, 32'h0F00, 8'd63,  32'h1000, 8'd235, 0};

    cyc = 0; read_addr = '0; read_num = '0; cfg_stall = 0; cfg_toggle = 0;
    cfg_resp_beat = 0; cfg_early_last = 0; cfg_drop_last = 0;
    stats_clear();
    do_reset();
    chk_all_zero("reset");
    chk("arsize", {29'd0, m_axi_arsize}, 32'd2);
    chk("arburst", {30'd0, m_axi_arburst}, 32'd1);

    for (int i = 0; i < 9; i++) run_vector(vecs[i], 1'b1, 1'b0);

    // kick while busy must be ignored
    v = '{32'h6000, 32'd8, 3, 1, 0, 0, 0, 1, 32'h6000, 8'd7, 32'h6000, 8'd7, 0};
    run_vector(v, 1'b1, 1'b1);

    // zero-length request: busy high two cycles, no AR
    do_reset();
    stats_clear();
    read_addr = 32'h1000; read_num = 32'd0; kick = 1;
    busy_cnt = 0;
    step();
    kick = 0;
    if (busy) busy_cnt++;
    repeat (6) begin step(); if (busy) busy_cnt++; end
    chk("zero_busy_cycles", busy_cnt, 2);
    chk("zero_no_ar", any_arvalid, 0);
    chk("zero_words", words, 0);

    // reset in the middle of a burst
    do_reset();
    stats_clear();
    cfg_stall = 0; cfg_toggle = 0; cfg_resp_beat = 0; cfg_early_last = 0; cfg_drop_last = 0;
    for (int i = 0; i < 64; i++) exp_q.push_back(32'hD000_0000 + 32'(i));
    read_addr = 32'h0; read_num = 32'd64; kick = 1;
    step();
    kick = 0;
    budget = 0;
    while (words < 10 && budget < 200) begin step(); budget++; end
    chk("pre_reset_words", words, 10);
    #2 rst = 1;
    #1 chk_all_zero("midrst");
    slave_clear();
    stats_clear();
    step();
    step();
    rst = 0;
    step();
    chk_all_zero("post_rst");
    run_vector(vecs[0], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
